// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 raster constants and a small window-compare helper
// used by the axis counters.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam logic SYNC_ACTIVE = 1'b0;

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    function automatic logic in_window(input logic [9:0] value,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with a registered sync pulse
// computed from the next count so it lines up with the count it describes.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   TOTAL      = H_TOTAL,
    parameter int   SYNC_START = H_SYNC_START,
    parameter int   SYNC_END   = H_SYNC_END,
    parameter int   DISPLAY    = H_DISPLAY,
    parameter logic SYNC_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] count,
    output logic       wrap,
    output logic       sync,
    output logic       active
);

    localparam logic [9:0] LAST_W       = 10'(TOTAL - 1);
    localparam logic [9:0] SYNC_START_W = 10'(SYNC_START);
    localparam logic [9:0] SYNC_END_W   = 10'(SYNC_END);
    localparam logic [9:0] DISPLAY_W    = 10'(DISPLAY);

    logic [9:0] count_r;
    logic [9:0] count_next_s;
    logic       wrap_s;
    logic       sync_r;

    // Next count and end-of-axis flag.
    always_comb begin
        count_next_s = count_r;
        wrap_s       = 1'b0;
        if (en) begin
            if (count_r == LAST_W) begin
                count_next_s = 10'd0;
                wrap_s       = 1'b1;
            end else begin
                count_next_s = count_r + 10'd1;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Count and sync state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 10'd0;
            sync_r  <= ~SYNC_LEVEL;
        end else begin
            count_r <= count_next_s;
            sync_r  <= in_window(count_next_s, SYNC_START_W, SYNC_END_W) ? SYNC_LEVEL : ~SYNC_LEVEL;
        end
    end

    assign count  = count_r;
    assign wrap   = wrap_s;
    assign sync   = sync_r;
    assign active = (count_r < DISPLAY_W);

endmodule

// File: rtl/vga_hvsync_gen.sv
// Free-running VGA raster timing generator: horizontal axis counts every
// pixel clock, vertical axis advances on each horizontal wrap.
module vga_hvsync_gen #(
    parameter int   H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
    parameter int   H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK      = vga_timing_pkg::H_BACK,
    parameter int   V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
    parameter int   V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK      = vga_timing_pkg::V_BACK,
    parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int HT  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int VT  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HSS = H_DISPLAY + H_FRONT;
    localparam int VSS = V_DISPLAY + V_FRONT;

    logic h_wrap_s;
    logic h_active_s;
    logic v_active_s;
    logic v_wrap_unused_s;

    vga_axis_counter #(
        .TOTAL      (HT),
        .SYNC_START (HSS),
        .SYNC_END   (HSS + H_SYNC - 1),
        .DISPLAY    (H_DISPLAY),
        .SYNC_LEVEL (SYNC_ACTIVE)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .en     (1'b1),
        .count  (hpos),
        .wrap   (h_wrap_s),
        .sync   (hsync),
        .active (h_active_s)
    );

    // Vertical axis steps on the same edge that the horizontal axis wraps.
    vga_axis_counter #(
        .TOTAL      (VT),
        .SYNC_START (VSS),
        .SYNC_END   (VSS + V_SYNC - 1),
        .DISPLAY    (V_DISPLAY),
        .SYNC_LEVEL (SYNC_ACTIVE)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .en     (h_wrap_s),
        .count  (vpos),
        .wrap   (v_wrap_unused_s),
        .sync   (vsync),
        .active (v_active_s)
    );

    assign display_on = h_active_s & v_active_s;

endmodule

// File: tb/tb_vga_hvsync_gen.sv
// Directed bench: a full-size instance for line-level timing and a shrunken
// instance (15x13 raster) so whole frames fit in a short run.
module tb_vga_hvsync_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;
    logic       s_hsync, s_vsync, s_display_on;
    logic [9:0] s_hpos, s_vpos;

    int checks   = 0;
    int failures = 0;

    int b_hlow = 0, b_don = 0, s_don = 0, s_vlow = 0, s_hlow = 0, s_hlow_in_v = 0;
    int last_evt = 0, n_evt = 0;
    int max_bh = 0, max_bv = 0, max_sh = 0, max_sv = 0;

    always #5 clk = ~clk;

    vga_hvsync_gen dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
        .display_on(display_on), .hpos(hpos), .vpos(vpos)
    );

    // Small raster: H 8+2+3+2=15 (hsync at 10..12), V 6+2+2+3=13 (vsync lines 8..9).
    vga_hvsync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE(1'b0)
    ) dut_s (
        .clk(clk), .reset(reset), .hsync(s_hsync), .vsync(s_vsync),
        .display_on(s_display_on), .hpos(s_hpos), .vpos(s_vpos)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k = number of rising edges since the raster sat at 0,0.
    task automatic observe(input int k);
        int bh, bv, sh, sv;
        bh = k % 800;
        bv = (k / 800) % 525;
        sh = k % 15;
        sv = (k / 15) % 13;
        chk("b_hpos", int'(hpos), bh);
        chk("b_vpos", int'(vpos), bv);
        chk("b_hsync", int'(hsync), (bh >= 656 && bh <= 751) ? 0 : 1);
        chk("b_vsync", int'(vsync), (bv >= 490 && bv <= 491) ? 0 : 1);
        chk("b_disp", int'(display_on), (bh < 640 && bv < 480) ? 1 : 0);
        chk("s_hpos", int'(s_hpos), sh);
        chk("s_vpos", int'(s_vpos), sv);
        chk("s_hsync", int'(s_hsync), (sh >= 10 && sh <= 12) ? 0 : 1);
        chk("s_vsync", int'(s_vsync), (sv >= 8 && sv <= 9) ? 0 : 1);
        chk("s_disp", int'(s_display_on), (sh < 8 && sv < 6) ? 1 : 0);
        if (k < 800) begin
            b_hlow += (hsync == 1'b0) ? 1 : 0;
            b_don  += (display_on == 1'b1) ? 1 : 0;
        end
        if (k < 195) begin
            s_don  += (s_display_on == 1'b1) ? 1 : 0;
            s_vlow += (s_vsync == 1'b0) ? 1 : 0;
            s_hlow += (s_hsync == 1'b0) ? 1 : 0;
            s_hlow_in_v += (s_hsync == 1'b0 && s_vsync == 1'b0) ? 1 : 0;
        end
        if (k > 0 && s_hpos == 10'd0 && s_vpos == 10'd0) begin
            chk("s_frame_gap", k - last_evt, 195);
            last_evt = k;
            n_evt++;
        end
        if (k == 799) begin
            chk("b_last_col", int'(hpos), 799);
            chk("b_last_col_v", int'(vpos), 0);
        end
        if (k == 800) begin
            chk("b_hwrap", int'(hpos), 0);
            chk("b_vinc", int'(vpos), 1);
        end
        if (int'(hpos) > max_bh) max_bh = int'(hpos);
        if (int'(vpos) > max_bv) max_bv = int'(vpos);
        if (int'(s_hpos) > max_sh) max_sh = int'(s_hpos);
        if (int'(s_vpos) > max_sv) max_sv = int'(s_vpos);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) step();
        chk("rst_hpos", int'(hpos), 0);
        chk("rst_vpos", int'(vpos), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_disp", int'(display_on), 1);
        observe(0);
        reset = 1'b0;
        step();
        chk("first_inc", int'(hpos), 1);
        observe(1);
        // k = 1886 puts the small raster at hpos 11, vpos 8: both syncs active.
        for (int k = 2; k <= 1886; k++) begin
            step();
            observe(k);
        end
        chk("mid_s_hpos", int'(s_hpos), 11);
        chk("mid_s_vpos", int'(s_vpos), 8);
        chk("mid_s_hsync", int'(s_hsync), 0);
        chk("mid_s_vsync", int'(s_vsync), 0);

        reset = 1'b1;
        step();
        chk("mrst_s_hpos", int'(s_hpos), 0);
        chk("mrst_s_vpos", int'(s_vpos), 0);
        chk("mrst_s_hsync", int'(s_hsync), 1);
        chk("mrst_s_vsync", int'(s_vsync), 1);
        chk("mrst_s_disp", int'(s_display_on), 1);
        chk("mrst_b_hpos", int'(hpos), 0);
        chk("mrst_b_vpos", int'(vpos), 0);
        reset = 1'b0;
        step();
        chk("post_b_hpos", int'(hpos), 1);
        chk("post_s_hpos", int'(s_hpos), 1);

        chk("b_hsync_width", b_hlow, 96);
        chk("b_disp_line", b_don, 640);
        chk("s_disp_frame", s_don, 48);
        chk("s_vsync_clocks", s_vlow, 30);
        chk("s_hsync_frame", s_hlow, 39);
        chk("s_hsync_in_vsync", s_hlow_in_v, 6);
        chk("s_frame_count", n_evt, 9);
        chk("b_max_h", max_bh, 799);
        chk("b_max_v", max_bv, 2);
        chk("s_max_h", max_sh, 14);
        chk("s_max_v", max_sv, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
